// File: rtl/step_debug_ctrl.sv
// step_debug_ctrl: button front end, STEP/RUN clock-enable FSM,
// PC breakpoint and LED view multiplexer.
// Ports:
//   clock, reset (async, active high)
//   btn_step, btn_mode, btn_sel: raw async buttons
//   ch_data: NUM_CH packed channels; pc, bp_addr, bp_en: breakpoint
//   cpu_en: 1-cycle enable pulses; run_mode: 0 STEP / 1 RUN
//   bp_hit: sticky halt flag; view, led: LED mux; cycle_count
module step_debug_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_CH          = 4,
  parameter int LED_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 5000000,
  parameter int CNT_WIDTH       = 32,
  localparam int PARTS = DATA_WIDTH / LED_WIDTH,
  localparam int NV    = NUM_CH * PARTS,
  localparam int VW    = (NV > 1) ? $clog2(NV) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         btn_step,
  input  logic                         btn_mode,
  input  logic                         btn_sel,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic [DATA_WIDTH-1:0]        pc,
  input  logic [DATA_WIDTH-1:0]        bp_addr,
  input  logic                         bp_en,
  output logic                         cpu_en,
  output logic                         run_mode,
  output logic                         bp_hit,
  output logic [VW-1:0]                view,
  output logic [LED_WIDTH-1:0]         led,
  output logic [CNT_WIDTH-1:0]         cycle_count
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DBW-1:0] DB_LAST =
    DBW'(DEBOUNCE_CYCLES - 1);

  localparam int DVW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DVW-1:0] DIV_LAST = DVW'(RUN_DIV - 1);

  localparam logic [VW-1:0] VIEW_LAST = VW'(NV - 1);

  // bit 0 step, bit 1 mode, bit 2 sel
  logic [2:0]     raw;
  logic [2:0]     s1;
  logic [2:0]     s2;
  logic [2:0]     acc;
  logic [2:0]     prs;
  logic [DBW-1:0] dbc [3];

  assign raw = {btn_sel, btn_mode, btn_step};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1  <= '0;
      s2  <= '0;
      acc <= '0;
      prs <= '0;
      for (int i = 0; i < 3; i++) dbc[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        prs[i] <= 1'b0;
        if (s2[i] == acc[i]) begin
          dbc[i] <= '0;
        end else if (dbc[i] == DB_LAST) begin
          dbc[i] <= '0;
          acc[i] <= s2[i];
          // only a press (0->1) yields a pulse
          prs[i] <= s2[i];
        end else begin
          dbc[i] <= dbc[i] + 1'b1;
        end
      end
    end
  end

  logic step_p;
  logic mode_p;
  logic sel_p;

  assign step_p = prs[0];
  assign mode_p = prs[1];
  assign sel_p  = prs[2];

  typedef enum logic {
    STEP = 1'b0,
    RUN  = 1'b1
  } mode_e;

  mode_e          state_q;
  mode_e          state_d;
  logic [DVW-1:0] div_q;
  logic [DVW-1:0] div_d;
  logic           en_q;
  logic           en_d;
  logic           supp_q;
  logic           supp_d;
  logic           hit_q;
  logic           hit_d;
  logic           bp_stop;

  // a live match also masks an enable already in flight
  assign bp_stop = (state_q == RUN) && bp_en &&
                   (pc == bp_addr) && !supp_q;

  assign cpu_en   = en_q & ~bp_stop;
  assign run_mode = (state_q == RUN);
  assign bp_hit   = hit_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    en_d    = 1'b0;
    supp_d  = supp_q;
    hit_d   = hit_q;
    if (cpu_en) supp_d = 1'b0;
    unique case (state_q)
      STEP: begin
        if (mode_p) begin
          state_d = RUN;
          div_d   = '0;
          hit_d   = 1'b0;
          supp_d  = 1'b1;
        end else if (step_p) begin
          en_d = 1'b1;
        end
      end
      RUN: begin
        if (bp_stop) begin
          state_d = STEP;
          hit_d   = 1'b1;
        end else if (mode_p) begin
          state_d = STEP;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          en_d  = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = STEP;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= STEP;
      div_q       <= '0;
      en_q        <= 1'b0;
      supp_q      <= 1'b0;
      hit_q       <= 1'b0;
      cycle_count <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      en_q    <= en_d;
      supp_q  <= supp_d;
      hit_q   <= hit_d;
      if (cpu_en) cycle_count <= cycle_count + 1'b1;
    end
  end

  // view v maps straight to LED slice v of the packed channels
  logic [LED_WIDTH-1:0] slc [NV];

  for (genvar g = 0; g < NV; g++) begin : g_slc
    assign slc[g] = ch_data[g*LED_WIDTH +: LED_WIDTH];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      view <= '0;
      led  <= '0;
    end else begin
      if (sel_p) begin
        view <= (view == VIEW_LAST) ? '0 : view + 1'b1;
      end
      led <= slc[view];
    end
  end

endmodule

// File: tb/tb_step_debug_ctrl.sv
// tb_step_debug_ctrl: directed bench for step_debug_ctrl.
// Small debounce/divider so every scenario runs in a few cycles.
module tb_step_debug_ctrl;

  localparam int DW = 32;
  localparam int NC = 2;
  localparam int LW = 16;
  localparam int DB = 4;
  localparam int RD = 3;
  localparam int CW = 32;

  logic           clock = 1'b0;
  logic           reset;
  logic [2:0]     btn;
  logic [NC*DW-1:0] ch_data;
  logic [DW-1:0]  pc;
  logic [DW-1:0]  bp_addr;
  logic           bp_en;
  logic           cpu_en;
  logic           run_mode;
  logic           bp_hit;
  logic [1:0]     view;
  logic [LW-1:0]  led;
  logic [CW-1:0]  cycle_count;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  step_debug_ctrl #(
    .DATA_WIDTH     (DW),
    .NUM_CH         (NC),
    .LED_WIDTH      (LW),
    .DEBOUNCE_CYCLES(DB),
    .RUN_DIV        (RD),
    .CNT_WIDTH      (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_step   (btn[0]),
    .btn_mode   (btn[1]),
    .btn_sel    (btn[2]),
    .ch_data    (ch_data),
    .pc         (pc),
    .bp_addr    (bp_addr),
    .bp_en      (bp_en),
    .cpu_en     (cpu_en),
    .run_mode   (run_mode),
    .bp_hit     (bp_hit),
    .view       (view),
    .led        (led),
    .cycle_count(cycle_count)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_n(2);
    reset = 1'b0;
    tick();
  endtask

  task automatic tap(input int b);
    btn[b] = 1'b1;
    wait_n(8);
    btn[b] = 1'b0;
    wait_n(8);
  endtask

  logic [15:0] exp_led [4];
  logic [1:0]  exp_view [4];

  initial begin
    int rise;
    int seen;
    int hit;
    logic [CW-1:0] cc;

    reset   = 1'b1;
    btn     = '0;
    pc      = '0;
    bp_addr = 32'h8;
    bp_en   = 1'b0;
    ch_data = {32'h12345678, 32'hAAAA5555};
    exp_led  = '{16'hAAAA, 16'h5678, 16'h1234, 16'h5555};
    exp_view = '{2'd1, 2'd2, 2'd3, 2'd0};

    wait_n(2);
    check("rst_outs",
          {cpu_en, run_mode, bp_hit, view, led, cycle_count},
          '0);
    reset = 1'b0;
    tick();

    // glitch shorter than debounce window
    btn[0] = 1'b1;
    wait_n(3);
    btn[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_en) seen++;
    end
    check("glitch_en", seen, 0);

    // held press: enable exactly 7 cycles after the edge
    btn[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("step_lat%0d", i), cpu_en, (i == 7));
    end
    check("step_cnt", cycle_count, 1);
    btn[0] = 1'b0;
    wait_n(8);
    check("step_rel", cycle_count, 1);

    // RUN cadence
    do_reset();
    btn[1] = 1'b1;
    rise = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (run_mode) begin
        rise = i;
        break;
      end
    end
    check("mode_rise", rise, 7);
    btn[1] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      check($sformatf("run_cad%0d", k), cpu_en, (k % 3 == 0));
    end
    tick();
    check("run_cnt", cycle_count, 10);
    btn[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!run_mode) break;
    end
    check("run_stop", run_mode, 0);
    btn[1] = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_en) seen++;
    end
    check("stop_quiet", seen, 0);

    // breakpoint halt and resume
    do_reset();
    bp_en = 1'b1;
    pc    = 32'h0;
    tap(1);
    check("bp_inrun", run_mode, 1);
    pc = 32'h8;
    #1;
    check("bp_gate", cpu_en, 0);
    cc = cycle_count;
    tick();
    check("bp_halt", {run_mode, bp_hit, cpu_en}, 3'b010);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cpu_en) seen++;
    end
    check("bp_quiet", seen, 0);
    check("bp_cnt", cycle_count, cc);
    btn[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (run_mode) break;
    end
    check("bp_resume", {run_mode, bp_hit}, 2'b10);
    btn[1] = 1'b0;
    hit = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_en) begin
        hit = 1;
        break;
      end
    end
    check("bp_res_en", hit, 1);
    pc = 32'hC;
    tick();
    check("bp_norehalt", {run_mode, bp_hit}, 2'b10);
    wait_n(4);
    pc = 32'h8;
    tick();
    check("bp_rehalt", {run_mode, bp_hit}, 2'b01);
    bp_en = 1'b0;
    pc    = '0;

    // LED views
    do_reset();
    check("view0", {view, led}, {2'd0, 16'h5555});
    for (int i = 0; i < 4; i++) begin
      tap(2);
      check($sformatf("view_led%0d", i), led, exp_led[i]);
      check($sformatf("view_idx%0d", i), view, exp_view[i]);
    end

    // simultaneous mode + step: mode wins
    do_reset();
    btn[0] = 1'b1;
    btn[1] = 1'b1;
    seen = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (cpu_en) seen++;
    end
    check("simul_en", seen, 0);
    check("simul_mode", run_mode, 1);
    check("simul_cnt", cycle_count, 0);
    btn = '0;
    wait_n(8);

    // reset while RUN mid-count
    do_reset();
    tap(1);
    hit = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cpu_en) begin
        hit = 1;
        break;
      end
    end
    check("rr_pulse", hit, 1);
    tick();
    reset = 1'b1;
    tick();
    check("rr_outs",
          {cpu_en, run_mode, bp_hit, view, led, cycle_count},
          '0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_en || run_mode) seen++;
    end
    check("rr_quiet", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/step_debug_ctrl.md
# step_debug_ctrl

Debug controller for the FPGA build. Turns raw board buttons into a clean processor clock-enable with single-step and free-run modes, plus a PC breakpoint. Multiplexes several internal data channels onto the LED bank, one LED-wide slice at a time. Sits between the board I/O and the processor/memory top level, so the CPU runs on the real system clock instead of a raw button edge.

## Interface
- DATA_WIDTH, 32: width of each observed channel and of the PC/breakpoint compare.
- NUM_CH, 4: number of observed channels (≥1).
- LED_WIDTH, 16: LED bank width. DATA_WIDTH must be an integer multiple of LED_WIDTH.
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples required to accept a button change (≥2).
- RUN_DIV, 5000000: clocks per cpu_en pulse in RUN mode (≥1).
- CNT_WIDTH, 32: width of the cpu_en pulse counter.

Ports:
- clock  in  1: system clock; the single clock domain.
- reset  in  1: asynchronous, active-high reset.
- btn_step  in  1: raw step button, asynchronous.
- btn_mode  in  1: raw mode-toggle button, asynchronous.
- btn_sel  in  1: raw view-select button, asynchronous.
- ch_data  in  NUM_CH*DATA_WIDTH: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- pc  in  DATA_WIDTH: current processor PC.
- bp_addr  in  DATA_WIDTH: breakpoint address.
- bp_en  in  1: breakpoint enable.
- cpu_en  out  1: processor/memory clock enable. One-cycle pulses only.
- run_mode  out  1: 0 = STEP, 1 = RUN.
- bp_hit  out  1: sticky breakpoint-hit flag.
- view  out  clog2(NUM_CH*DATA_WIDTH/LED_WIDTH): current LED view index.
- led  out  LED_WIDTH: registered LED value.
- cycle_count  out  CNT_WIDTH: number of cpu_en pulses issued; wraps modulo 2^CNT_WIDTH.

## Operation
- Button front end, one per button:
  - 2-flop synchroniser.
  - Debounce counter. The accepted state flips only after the synchronised value differs from the accepted state for DEBOUNCE_CYCLES consecutive cycles. Any mismatch gap clears the counter.
  - Press pulse (1 cycle) on each accepted 0→1 transition. Releases produce no pulse.
- Mode FSM, two states (STEP, RUN):
  - STEP: each step pulse gives exactly one cpu_en pulse. A mode pulse moves to RUN, clears the divider, clears bp_hit and arms breakpoint suppression.
  - RUN: the divider counts 0..RUN_DIV-1. cpu_en pulses when divider == RUN_DIV-1, then the divider wraps to 0. Step pulses are ignored. A mode pulse moves to STEP.
  - Breakpoint in RUN: if bp_en && pc == bp_addr && suppression is clear, then:
    - cpu_en is forced low that cycle;
    - the state moves to STEP;
    - bp_hit sets.
  - Suppression clears on the first cpu_en pulse after entering RUN. This lets the processor leave the breakpoint address when resuming.
- Simultaneous mode and step pulses: the mode pulse wins and the step pulse is dropped.
- Views:
  - PARTS = DATA_WIDTH/LED_WIDTH.
  - View v shows channel v/PARTS, slice v%PARTS. Slice 0 is the least-significant LED_WIDTH bits.
  - A sel pulse increments view, wrapping from NUM_CH*PARTS-1 to 0.
- cycle_count increments on every cpu_en pulse.

## Timing
- Reset (async assert, sync release) values:
  - cpu_en = 0, run_mode = 0, bp_hit = 0, view = 0, led = 0, cycle_count = 0;
  - divider = 0, debounce counters = 0, accepted states = 0, suppression = 0.
- Button latency, with raw input stable high from cycle 0:
  - synchronised value valid at cycle 2;
  - accepted state flips at cycle 2+DEBOUNCE_CYCLES;
  - press pulse asserted during the following cycle.
- Step pulse in cycle t gives cpu_en high in cycle t+1 only.
- A mode pulse in cycle t changes run_mode in cycle t+1. The first RUN cpu_en pulse occurs RUN_DIV cycles after run_mode rises.
- A breakpoint match in cycle t gives run_mode = 0 and bp_hit = 1 in cycle t+1, with no cpu_en in t or t+1.
- led is registered: it reflects view and ch_data from the previous cycle.
- cycle_count updates in the cycle after cpu_en is high.
- Reset mid-operation: all state returns to reset values immediately, and any pending pulse is lost.

## Test plan
- Debounce, with DEBOUNCE_CYCLES = 4: a 3-cycle glitch on btn_step gives no pulse and cpu_en stays 0. A held press gives exactly one cpu_en pulse, 7 cycles after the press edge, and cycle_count = 1.
- RUN cadence, with RUN_DIV = 3: after a mode press, cpu_en pulses every 3rd cycle. After 10 pulses cycle_count = 10. A second mode press stops pulses and run_mode = 0.
- Breakpoint, with bp_en = 1 and bp_addr = 0x8: drive pc to 0x8 while in RUN. Expect run_mode → 0, bp_hit = 1 and no cpu_en. A mode press then resumes: one cpu_en is issued with pc still 0x8, bp_hit clears, and the processor is not re-halted.
- Views, with NUM_CH = 2, DATA_WIDTH = 32, LED_WIDTH = 16 and ch0 = 0xAAAA5555, ch1 = 0x12345678: successive sel presses give led = 0x5555, 0xAAAA, 0x5678, 0x1234, then 0x5555 again (wrap).
- Simultaneous presses: mode and step pulses in the same cycle while in STEP give run_mode = 1 and no step cpu_en.
- Reset while RUN is active with divider mid-count: all outputs are 0 on the next cycle and there is no spurious cpu_en after release.
